// File: rtl/apb_slave_demux_if.sv
// Upstream APB bus between the master mux and the slave demux.
// The mux drives the request side; the demux returns the response.
interface apb_slave_demux_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic [2:0]        PPROT;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_demux.sv
// Routes one arbitrated APB transfer to a peripheral by address decode.
// Unmapped addresses and hung slaves complete upstream with PSLVERR.
module apb_slave_demux #(
    parameter int NUM_APB_SLAVES = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_STRB_WIDTH = 4,
    parameter logic [APB_ADDR_WIDTH-1:0] SLV_MASK = 32'hF000_0000,
    parameter logic [NUM_APB_SLAVES*APB_ADDR_WIDTH-1:0] SLV_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                     PCLK,
    input  logic                                     PRESETn,
    apb_slave_demux_if.slave                         up,
    output logic [NUM_APB_SLAVES-1:0]                PSEL_d,
    output logic                                     PENABLE_d,
    output logic                                     PWRITE_d,
    output logic [APB_ADDR_WIDTH-1:0]                PADDR_d,
    output logic [APB_DATA_WIDTH-1:0]                PWDATA_d,
    output logic [APB_STRB_WIDTH-1:0]                PSTRB_d,
    output logic [2:0]                               PPROT_d,
    input  logic [NUM_APB_SLAVES*APB_DATA_WIDTH-1:0] PRDATA_d,
    input  logic [NUM_APB_SLAVES-1:0]                PREADY_d,
    input  logic [NUM_APB_SLAVES-1:0]                PSLVERR_d,
    output logic [7:0]                               decerr_cnt,
    output logic [7:0]                               tmo_cnt
);

    localparam int IDX_W = (NUM_APB_SLAVES > 1) ? $clog2(NUM_APB_SLAVES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, D_SETUP, D_ACCESS, RESP} state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [TMR_W-1:0]          timer;
    logic [APB_DATA_WIDTH-1:0] rsp_data;
    logic                      rsp_err;

    logic                      hit;
    logic [IDX_W-1:0]          hit_idx;
    logic                      sel_ready;
    logic                      sel_err;
    logic [APB_DATA_WIDTH-1:0] sel_rdata;

    // Scanning downward lets the lowest matching index win on overlapping bases.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_APB_SLAVES - 1; i >= 0; i--) begin
            if ((up.PADDR & SLV_MASK) == SLV_BASE[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign sel_ready = PREADY_d[idx];
    assign sel_err   = PSLVERR_d[idx];
    assign sel_rdata = PRDATA_d[idx*APB_DATA_WIDTH +: APB_DATA_WIDTH];

    assign up.PREADY  = (state == RESP) && up.PSEL && up.PENABLE;
    assign up.PSLVERR = (state == RESP) && rsp_err;
    assign up.PRDATA  = (state == RESP) ? rsp_data : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            idx        <= '0;
            timer      <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            PSEL_d     <= '0;
            PENABLE_d  <= 1'b0;
            PWRITE_d   <= 1'b0;
            PADDR_d    <= '0;
            PWDATA_d   <= '0;
            PSTRB_d    <= '0;
            PPROT_d    <= '0;
            decerr_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (up.PSEL && !up.PENABLE) begin
                        PWRITE_d <= up.PWRITE;
                        PADDR_d  <= up.PADDR;
                        PWDATA_d <= up.PWDATA;
                        PSTRB_d  <= up.PSTRB;
                        PPROT_d  <= up.PPROT;
                        idx      <= hit_idx;
                        if (hit) begin
                            PSEL_d <= NUM_APB_SLAVES'(1) << hit_idx;
                            state  <= D_SETUP;
                        end else begin
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                            if (decerr_cnt != 8'hFF) decerr_cnt <= decerr_cnt + 8'd1;
                            state    <= RESP;
                        end
                    end
                end
                D_SETUP: begin
                    PENABLE_d <= 1'b1;
                    timer     <= '0;
                    state     <= D_ACCESS;
                end
                D_ACCESS: begin
                    // A ready on the final allowed cycle still counts as a real response.
                    if (sel_ready) begin
                        rsp_data  <= PWRITE_d ? '0 : sel_rdata;
                        rsp_err   <= sel_err;
                        PSEL_d    <= '0;
                        PENABLE_d <= 1'b0;
                        state     <= RESP;
                    end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        PSEL_d    <= '0;
                        PENABLE_d <= 1'b0;
                        if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
                        state     <= RESP;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                RESP: begin
                    // Losing PSEL before completion discards the response.
                    if (!up.PSEL || up.PENABLE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_slave_demux.md
Name: apb_slave_demux

Overview:
- Downstream stage of the APB master mux: takes the single arbitrated APB transfer and routes it to one of NUM_APB_SLAVES peripherals by address decode.
- Registers the request toward the slave and returns the slave response on the upstream port.
- Unmapped addresses and hung slaves (no PREADY within TIMEOUT_CYCLES) complete upstream with PSLVERR=1, so the mux never stalls.
- Keeps saturating decode-error and timeout counters for debug.

Parameters:
- NUM_APB_SLAVES, 4, number of downstream slaves (1..16).
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- APB_STRB_WIDTH, 4, write strobe width.
- SLV_MASK, 32'hF000_0000, decode mask, common to all slaves.
- SLV_BASE, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, packed NUM_APB_SLAVES×APB_ADDR_WIDTH; entry i is slave i's base.
- TIMEOUT_CYCLES, 16, maximum downstream ACCESS cycles before forced error (≥2).

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL, PENABLE, PWRITE  in  1  upstream APB controls, from the mux.
- PADDR  in  APB_ADDR_WIDTH  upstream address.
- PWDATA  in  APB_DATA_WIDTH  upstream write data.
- PSTRB  in  APB_STRB_WIDTH  upstream strobes.
- PPROT  in  3  upstream protection.
- PRDATA  out  APB_DATA_WIDTH  upstream read data.
- PREADY, PSLVERR  out  1  upstream response.
- PSEL_d  out  NUM_APB_SLAVES  one-hot downstream selects.
- PENABLE_d, PWRITE_d  out  1  downstream controls, shared by all slaves.
- PADDR_d, PWDATA_d, PSTRB_d, PPROT_d  out  as upstream widths  registered downstream payload, shared by all slaves.
- PRDATA_d  in  NUM_APB_SLAVES×APB_DATA_WIDTH  packed per-slave read data.
- PREADY_d, PSLVERR_d  in  NUM_APB_SLAVES  per-slave response.
- decerr_cnt, tmo_cnt  out  8  saturating error counters.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, timer 0. Assertion mid-transfer aborts immediately; no response is delivered afterwards.
- Decode: slave i is hit when (PADDR & SLV_MASK) == SLV_BASE[i]. On overlap the lowest index wins. No hit means decode error.
- FSM states: IDLE, D_SETUP, D_ACCESS, RESP.
- IDLE:
  - Enter on PSEL=1 && PENABLE=0 (setup phase).
  - Capture PADDR/PWRITE/PWDATA/PSTRB/PPROT into the _d registers and latch the slave index.
  - On hit, go to D_SETUP.
  - On miss, set rsp_err=1 and rsp_data=0, increment decerr_cnt, go to RESP.
- D_SETUP (1 cycle): PSEL_d[idx]=1, PENABLE_d=0. Go to D_ACCESS. Timer cleared.
- D_ACCESS:
  - PSEL_d[idx]=1, PENABLE_d=1. Timer increments each cycle.
  - If PREADY_d[idx]=1: capture PRDATA_d[idx] and PSLVERR_d[idx], deassert PSEL_d/PENABLE_d next cycle, go to RESP.
  - Else if timer == TIMEOUT_CYCLES-1: rsp_err=1, rsp_data=0, increment tmo_cnt, drop PSEL_d/PENABLE_d, go to RESP.
  - PREADY_d on the final timeout cycle wins over timeout.
- RESP:
  - Drive PRDATA=rsp_data (zero on writes) and PSLVERR=rsp_err.
  - PREADY=1 only while PENABLE=1. Leave to IDLE after the cycle in which PREADY=1 && PENABLE=1.
  - If upstream PSEL drops before that (protocol violation), discard the response and return to IDLE.
- Upstream PREADY is 0 in all other states, so the zero-wait minimum is 2 upstream wait states.
  - Setup at cycle 0, D_SETUP cycle 1, D_ACCESS cycle 2 (slave ready), PREADY cycle 3.
- Changes on upstream signals while busy are ignored.
- PSEL_d is always one-hot or zero. The _d payload stays stable from D_SETUP through the end of D_ACCESS.
- Counters saturate at 8'hFF. There is no clear other than reset.

Test Plan:
- Write to 32'h1000_0004, data AABB_CCDD, slave1 zero-wait:
  - PSEL_d=4'b0010 one cycle with PENABLE_d=0, then one cycle with PENABLE_d=1; PWDATA_d=AABB_CCDD.
  - Upstream PREADY=1, PSLVERR=0 exactly 3 cycles after setup.
- Read 32'h2000_0010 with slave2 PREADY_d delayed 3 cycles, PRDATA_d[2]=DE00_0010 -> PRDATA=DE00_0010, PREADY 6 cycles after setup, PSLVERR=0.
- Read 32'h5000_0000 (unmapped):
  - No PSEL_d asserted.
  - PREADY=1 with PSLVERR=1 and PRDATA=0 on the first PENABLE=1 cycle.
  - decerr_cnt becomes 1.
- Slave3 never ready, access to 32'h3000_0000:
  - PSEL_d[3] held through 16 ACCESS cycles, then dropped.
  - Upstream PSLVERR=1, tmo_cnt=1.
  - A following access to slave0 completes normally.
- Slave0 returns PSLVERR_d=1 on a write -> upstream PSLVERR=1, counters unchanged.
- PRESETn pulsed low during slave1 D_ACCESS -> all outputs 0 asynchronously; after release, a fresh read to slave1 completes with correct data.
